// File: rtl/gf180mcu_fd_sc_mcu7t5v0__buf_bank_sequencer.sv
// Staggered enable sequencer for NBANK parallel buf_2 banks sharing one net.
// Banks turn on bottom-up and off top-down, one per STEP_CYC clocks, to limit supply di/dt.
module gf180mcu_fd_sc_mcu7t5v0__buf_bank_sequencer #(
    parameter int NBANK    = 4,
    parameter int STEP_CYC = 8
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             EN,
    output logic [NBANK-1:0] BANK_EN,
    output logic [4:0]       LEVEL,
    output logic             READY,
    output logic             BUSY,
    inout  wire              VDD,
    inout  wire              VSS
);

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        UP   = 2'd1,
        ON   = 2'd2,
        DOWN = 2'd3
    } seqState;

    localparam logic [7:0] TIMER_LAST = 8'(STEP_CYC - 1);
    localparam logic [4:0] LEVEL_FULL = 5'(NBANK);

    seqState    state;
    logic [7:0] stepTimer;
    logic       stepDone;
    logic       unusedSupply;

    // Supply pins exist only for connectivity in the cell netlist.
    assign unusedSupply = VDD ^ VSS;

    assign stepDone = (stepTimer == TIMER_LAST);
    assign BUSY     = (state == UP) || (state == DOWN);

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state     <= OFF;
            stepTimer <= 8'd0;
            BANK_EN   <= '0;
            LEVEL     <= 5'd0;
            READY     <= 1'b0;
        end else begin
            case (state)
                OFF: begin
                    if (EN) begin
                        BANK_EN   <= {{(NBANK-1){1'b0}}, 1'b1};
                        LEVEL     <= 5'd1;
                        stepTimer <= 8'd0;
                        if (LEVEL_FULL == 5'd1) begin
                            state <= ON;
                            READY <= 1'b1;
                        end else begin
                            state <= UP;
                        end
                    end
                end
                UP: begin
                    // A dropped request wins over a pending step so no extra bank is switched on.
                    if (!EN) begin
                        state     <= DOWN;
                        stepTimer <= 8'd0;
                    end else if (stepDone) begin
                        BANK_EN   <= {BANK_EN[NBANK-2:0], 1'b1};
                        LEVEL     <= LEVEL + 5'd1;
                        stepTimer <= 8'd0;
                        if (LEVEL + 5'd1 == LEVEL_FULL) begin
                            state <= ON;
                            READY <= 1'b1;
                        end
                    end else begin
                        stepTimer <= stepTimer + 8'd1;
                    end
                end
                ON: begin
                    if (!EN) begin
                        BANK_EN   <= BANK_EN >> 1;
                        LEVEL     <= LEVEL - 5'd1;
                        READY     <= 1'b0;
                        stepTimer <= 8'd0;
                        state     <= DOWN;
                    end
                end
                DOWN: begin
                    if (EN) begin
                        state     <= UP;
                        stepTimer <= 8'd0;
                    end else if (stepDone) begin
                        BANK_EN   <= BANK_EN >> 1;
                        LEVEL     <= LEVEL - 5'd1;
                        stepTimer <= 8'd0;
                        if (LEVEL == 5'd1) begin
                            state <= OFF;
                        end
                    end else begin
                        stepTimer <= stepTimer + 8'd1;
                    end
                end
                default: begin
                    state <= OFF;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__buf_bank_sequencer.sv
// Directed bench for the bank sequencer at NBANK=4, STEP_CYC=3, followed by a
// random EN run that watches the thermometer/level/ready invariants.
module tb_gf180mcu_fd_sc_mcu7t5v0__buf_bank_sequencer;

    logic       CLK;
    logic       RN;
    logic       EN;
    logic [3:0] BANK_EN;
    logic [4:0] LEVEL;
    logic       READY;
    logic       BUSY;
    wire        vdd;
    wire        vss;

    int testsRun  = 0;
    int failCount = 0;

    assign vdd = 1'b1;
    assign vss = 1'b0;

    gf180mcu_fd_sc_mcu7t5v0__buf_bank_sequencer #(
        .NBANK    (4),
        .STEP_CYC (3)
    ) dut (
        .CLK     (CLK),
        .RN      (RN),
        .EN      (EN),
        .BANK_EN (BANK_EN),
        .LEVEL   (LEVEL),
        .READY   (READY),
        .BUSY    (BUSY),
        .VDD     (vdd),
        .VSS     (vss)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Drive EN, then advance the given number of rising edges; outputs settle 1 time unit later.
    task automatic applyStimulus(input logic en, input int cycles);
        EN = en;
        repeat (cycles) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] expBank, input logic [4:0] expLevel,
                               input logic expReady, input logic expBusy);
        testsRun++;
        assert (BANK_EN === expBank) else begin
            failCount++;
            $error("[TB] FAIL %s BANK_EN observed=%b expected=%b", tag, BANK_EN, expBank);
        end
        testsRun++;
        assert (LEVEL === expLevel) else begin
            failCount++;
            $error("[TB] FAIL %s LEVEL observed=%0d expected=%0d", tag, LEVEL, expLevel);
        end
        testsRun++;
        assert (READY === expReady) else begin
            failCount++;
            $error("[TB] FAIL %s READY observed=%b expected=%b", tag, READY, expReady);
        end
        testsRun++;
        assert (BUSY === expBusy) else begin
            failCount++;
            $error("[TB] FAIL %s BUSY observed=%b expected=%b", tag, BUSY, expBusy);
        end
    endtask

    initial begin
        logic [3:0] prevBank;
        RN = 1'b0;
        EN = 1'b1;

        // Reset held with EN high: nothing may turn on.
        applyStimulus(1'b1, 1);
        checkOutput("rst_hold0", 4'b0000, 5'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1);
        checkOutput("rst_hold1", 4'b0000, 5'd0, 1'b0, 1'b0);
        RN = 1'b1;

        // Ramp up: first edge after release is edge 0.
        applyStimulus(1'b1, 1);
        checkOutput("up_e0", 4'b0001, 5'd1, 1'b0, 1'b1);
        applyStimulus(1'b1, 2);
        checkOutput("up_e2", 4'b0001, 5'd1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1);
        checkOutput("up_e3", 4'b0011, 5'd2, 1'b0, 1'b1);
        applyStimulus(1'b1, 2);
        checkOutput("up_e5", 4'b0011, 5'd2, 1'b0, 1'b1);
        applyStimulus(1'b1, 1);
        checkOutput("up_e6", 4'b0111, 5'd3, 1'b0, 1'b1);
        applyStimulus(1'b1, 2);
        checkOutput("up_e8", 4'b0111, 5'd3, 1'b0, 1'b1);
        applyStimulus(1'b1, 1);
        checkOutput("up_e9", 4'b1111, 5'd4, 1'b1, 1'b0);
        applyStimulus(1'b1, 3);
        checkOutput("on_hold", 4'b1111, 5'd4, 1'b1, 1'b0);

        // Ramp down from ON.
        applyStimulus(1'b0, 1);
        checkOutput("dn_e0", 4'b0111, 5'd3, 1'b0, 1'b1);
        applyStimulus(1'b0, 2);
        checkOutput("dn_e2", 4'b0111, 5'd3, 1'b0, 1'b1);
        applyStimulus(1'b0, 1);
        checkOutput("dn_e3", 4'b0011, 5'd2, 1'b0, 1'b1);
        applyStimulus(1'b0, 3);
        checkOutput("dn_e6", 4'b0001, 5'd1, 1'b0, 1'b1);
        applyStimulus(1'b0, 2);
        checkOutput("dn_e8", 4'b0001, 5'd1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1);
        checkOutput("dn_e9", 4'b0000, 5'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 2);
        checkOutput("off_hold", 4'b0000, 5'd0, 1'b0, 1'b0);

        // Reversal UP->DOWN at edge 4 with two banks on.
        applyStimulus(1'b1, 1);
        checkOutput("rev_e0", 4'b0001, 5'd1, 1'b0, 1'b1);
        applyStimulus(1'b1, 3);
        checkOutput("rev_e3", 4'b0011, 5'd2, 1'b0, 1'b1);
        applyStimulus(1'b0, 1);
        checkOutput("rev_e4", 4'b0011, 5'd2, 1'b0, 1'b1);
        applyStimulus(1'b0, 2);
        checkOutput("rev_e6", 4'b0011, 5'd2, 1'b0, 1'b1);
        applyStimulus(1'b0, 1);
        checkOutput("rev_e7", 4'b0001, 5'd1, 1'b0, 1'b1);
        applyStimulus(1'b0, 3);
        checkOutput("rev_e10", 4'b0000, 5'd0, 1'b0, 1'b0);

        // Same start, but EN returns at edge 8: UP again from level 1.
        applyStimulus(1'b1, 4);
        checkOutput("rev2_e3", 4'b0011, 5'd2, 1'b0, 1'b1);
        applyStimulus(1'b0, 4);
        checkOutput("rev2_e7", 4'b0001, 5'd1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1);
        checkOutput("rev2_e8", 4'b0001, 5'd1, 1'b0, 1'b1);
        applyStimulus(1'b1, 2);
        checkOutput("rev2_e10", 4'b0001, 5'd1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1);
        checkOutput("rev2_e11", 4'b0011, 5'd2, 1'b0, 1'b1);
        applyStimulus(1'b0, 10);
        checkOutput("rev2_off", 4'b0000, 5'd0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a ramp, checked before any edge.
        applyStimulus(1'b1, 7);
        checkOutput("arst_pre", 4'b0111, 5'd3, 1'b0, 1'b1);
        #2;
        RN = 1'b0;
        #1;
        checkOutput("arst_now", 4'b0000, 5'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1);
        checkOutput("arst_hold", 4'b0000, 5'd0, 1'b0, 1'b0);
        RN = 1'b1;

        // Random EN with occasional toggles so ramps both complete and reverse.
        EN = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            prevBank = BANK_EN;
            if ($urandom_range(0, 7) == 0) EN = ~EN;
            applyStimulus(EN, 1);
            testsRun++;
            assert ((BANK_EN & (BANK_EN + 4'd1)) == 4'd0) else begin
                failCount++;
                $error("[TB] FAIL rnd_thermo cycle %0d observed=%b expected=thermometer", i, BANK_EN);
            end
            testsRun++;
            assert (LEVEL === 5'($countones(BANK_EN)) && LEVEL <= 5'd4) else begin
                failCount++;
                $error("[TB] FAIL rnd_level cycle %0d observed=%0d expected=%0d", i, LEVEL, $countones(BANK_EN));
            end
            testsRun++;
            assert ($countones(BANK_EN ^ prevBank) <= 1) else begin
                failCount++;
                $error("[TB] FAIL rnd_step cycle %0d observed=%b expected_from=%b", i, BANK_EN, prevBank);
            end
            testsRun++;
            assert (READY === (LEVEL == 5'd4)) else begin
                failCount++;
                $error("[TB] FAIL rnd_ready cycle %0d observed=%b expected=%b", i, READY, (LEVEL == 5'd4));
            end
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
